// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- ID-stage hazard controller for the 5-stage MIPS core.
//
// Sequences load-use bubbles, IF/ID flushes on taken branches, and a
// whole-pipeline freeze while a variable-latency data-memory access in MEM
// completes. A watchdog aborts a wait that never gets an ack.
//
// Optional feature macro: HAZARD_PERF_CNT_EN (adds stall/flush perf counters).
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   IDEX_MemRead_i          instruction in EX is a load
//   IDEX_RegisterRt_i       load destination in EX
//   IFID_RegisterRs_i/Rt_i  source registers of instruction in ID
//   Branch_taken_i          branch in ID resolved taken
//   EXMEM_MemRead_i/Write_i memory op present in MEM
//   DMem_ack_i              data memory completes current access
//   DMem_req_o              data memory request (level)
//   IsHazzard_o             insert bubble into ID/EX
//   PC_write_o              PC update enable
//   IFID_write_o            IF/ID register enable
//   IFID_flush_o            clear IF/ID to NOP
//   Freeze_o                hold ID/EX, EX/MEM, MEM/WB
//   Timeout_err_o           sticky watchdog error
//   Stall_cnt_o/Flush_cnt_o saturating perf counters (macro only)
//
// Handshake: DMem_req_o is a level request; an access completes in the
// cycle DMem_ack_i is sampled high while the request is up, and the
// pipeline advances on that cycle's clock edge. An ack with no request
// pending is ignored.

module hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [REG_W-1:0] IDEX_RegisterRt_i,
  input  logic [REG_W-1:0] IFID_RegisterRs_i,
  input  logic [REG_W-1:0] IFID_RegisterRt_i,
  input  logic             Branch_taken_i,
  input  logic             EXMEM_MemRead_i,
  input  logic             EXMEM_MemWrite_i,
  input  logic             DMem_ack_i,
  output logic             DMem_req_o,
  output logic             IsHazzard_o,
  output logic             PC_write_o,
  output logic             IFID_write_o,
  output logic             IFID_flush_o,
  output logic             Freeze_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]      Stall_cnt_o,
  output logic [31:0]      Flush_cnt_o,
`endif
  output logic             Timeout_err_o
);

  localparam logic [0:0] S_RUN      = 1'b0;
  localparam logic [0:0] S_MEM_WAIT = 1'b1;

  localparam int              WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [0:0]      state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  logic memop;
  logic in_wait;
  logic wd_expire;
  logic lu;
  logic req;
  logic freeze;

  assign memop   = EXMEM_MemRead_i | EXMEM_MemWrite_i;
  assign in_wait = (state_q == S_MEM_WAIT);

  // Last allowed wait cycle with no ack: abort and let the instruction advance.
  assign wd_expire = in_wait & ~DMem_ack_i & (wd_q == WD_LAST);

  assign req    = (~in_wait & memop) | in_wait;
  assign freeze = req & ~DMem_ack_i & ~wd_expire;

  assign lu = IDEX_MemRead_i & (IDEX_RegisterRt_i != '0) &
              ((IDEX_RegisterRt_i == IFID_RegisterRs_i) |
               (IDEX_RegisterRt_i == IFID_RegisterRt_i));

  // Next-state logic for the memory handshake FSM and watchdog.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      S_RUN: begin
        if (memop && !DMem_ack_i) begin
          state_d = S_MEM_WAIT;
          wd_d    = '0;
        end
      end
      S_MEM_WAIT: begin
        if (DMem_ack_i) begin
          state_d = S_RUN;
        end else if (wd_expire) begin
          state_d = S_RUN;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Prioritised hazard outputs: freeze > load-use > branch flush.
  always_comb begin
    IsHazzard_o  = 1'b0;
    PC_write_o   = 1'b0;
    IFID_write_o = 1'b0;
    IFID_flush_o = 1'b0;
    if (freeze) begin
      // everything held
    end else if (lu) begin
      // Coincident taken branch is dropped here; it is re-resolved next cycle.
      IsHazzard_o = 1'b1;
    end else begin
      PC_write_o   = 1'b1;
      IFID_write_o = 1'b1;
      IFID_flush_o = Branch_taken_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_RUN;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign DMem_req_o    = req;
  assign Freeze_o      = freeze;
  assign Timeout_err_o = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: hold at all-ones rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((freeze || IsHazzard_o) && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (IFID_flush_o && (flush_cnt_q != 32'hFFFF_FFFF))
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Stall_cnt_o = stall_cnt_q;
  assign Flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int REG_W   = 5;
  localparam int TIMEOUT = 8;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             idex_rd;
  logic [REG_W-1:0] idex_rt, ifid_rs, ifid_rt;
  logic             br, ex_rd, ex_wr, ack;
  logic             req_o, hz_o, pcw_o, ifw_o, fl_o, frz_o, err_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]      stall_o, flushc_o;
`endif

  hazard_ctrl #(.REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .IDEX_MemRead_i    (idex_rd),
    .IDEX_RegisterRt_i (idex_rt),
    .IFID_RegisterRs_i (ifid_rs),
    .IFID_RegisterRt_i (ifid_rt),
    .Branch_taken_i    (br),
    .EXMEM_MemRead_i   (ex_rd),
    .EXMEM_MemWrite_i  (ex_wr),
    .DMem_ack_i        (ack),
    .DMem_req_o        (req_o),
    .IsHazzard_o       (hz_o),
    .PC_write_o        (pcw_o),
    .IFID_write_o      (ifw_o),
    .IFID_flush_o      (fl_o),
    .Freeze_o          (frz_o),
`ifdef HAZARD_PERF_CNT_EN
    .Stall_cnt_o       (stall_o),
    .Flush_cnt_o       (flushc_o),
`endif
    .Timeout_err_o     (err_o)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  // Tracks whether a memory access is outstanding and for how many cycles
  // it has been waiting; outputs follow the priority rules directly.
  bit      m_busy   = 1'b0;
  int      m_waited = 0;
  bit      m_err    = 1'b0;
  longint  m_stall  = 0;
  longint  m_flush  = 0;

  // Per-step observations used by directed tallies.
  int n_req, n_frz;

  task automatic step(input bit r, input bit ld, input int rt_ex, input int rs_id,
                      input int rt_id, input bit b, input bit mrd, input bit mwr,
                      input bit a);
    bit memop, e_req, e_tmo, e_frz, e_lu, e_hz, e_fl, e_pcw;
    rst     = r;
    idex_rd = ld;
    idex_rt = REG_W'(rt_ex);
    ifid_rs = REG_W'(rs_id);
    ifid_rt = REG_W'(rt_id);
    br      = b;
    ex_rd   = mrd;
    ex_wr   = mwr;
    ack     = a;
    @(negedge clk);
    memop = mrd || mwr;
    e_req = m_busy || memop;
    e_tmo = m_busy && !a && (m_waited == TIMEOUT - 1);
    e_frz = e_req && !a && !e_tmo;
    e_lu  = ld && (rt_ex != 0) && (rt_ex == rs_id || rt_ex == rt_id);
    e_hz  = !e_frz && e_lu;
    e_fl  = !e_frz && !e_lu && b;
    e_pcw = !e_frz && !e_lu;
    chk("dmem_req", 32'(req_o), 32'(e_req));
    chk("freeze",   32'(frz_o), 32'(e_frz));
    chk("hazard",   32'(hz_o),  32'(e_hz));
    chk("flush",    32'(fl_o),  32'(e_fl));
    chk("pc_write", 32'(pcw_o), 32'(e_pcw));
    chk("ifid_wr",  32'(ifw_o), 32'(e_pcw));
    chk("tmo_err",  32'(err_o), 32'(m_err));
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt", stall_o,  32'(m_stall));
    chk("flush_cnt", flushc_o, 32'(m_flush));
`endif
    n_req += int'(req_o);
    n_frz += int'(frz_o);
    @(posedge clk);
    if (r) begin
      m_busy = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (e_frz || e_hz) m_stall++;
      if (e_fl) m_flush++;
      if (m_busy) begin
        if (a || e_tmo) m_busy = 0;
        else m_waited++;
        if (e_tmo) m_err = 1;
      end else if (memop && !a) begin
        m_busy   = 1;
        m_waited = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; idex_rd = 0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
    br = 0; ex_rd = 0; ex_wr = 0; ack = 0;
    @(posedge clk); #1;
    do_reset();

    // Reset outputs with inputs idle.
    idle(1);
    chk("rst_pc_write", 32'(pcw_o), 32'd1);

    // Load-use: one-cycle bubble, then the bubble clears the load in EX.
    step(0, 1, 5, 5, 0, 0, 0, 0, 0);
    step(0, 0, 5, 5, 0, 0, 0, 0, 0);
    // Load into $0 never stalls.
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    // Match on Rt source.
    step(0, 1, 7, 1, 7, 0, 0, 0, 0);

    // Taken branch alone flushes; with load-use it waits a cycle.
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 3, 3, 0, 1, 0, 0, 0);
    step(0, 0, 3, 3, 0, 1, 0, 0, 0);
    idle(1);

    // Memory wait, ack three cycles after the first request.
    n_req = 0; n_frz = 0;
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("wait_req_cycles", 32'(n_req), 32'd4);
    chk("wait_frz_cycles", 32'(n_frz), 32'd3);
    idle(1);

    // Zero-wait store and an ack with nothing pending.
    n_frz = 0;
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("zero_wait_frz", 32'(n_frz), 32'd0);

    // Watchdog timeout: no ack ever.
    n_frz = 0;
    for (int i = 0; i < TIMEOUT + 1; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("tmo_frz_cycles", 32'(n_frz), 32'(TIMEOUT));
    idle(3);
    chk("tmo_sticky", 32'(err_o), 32'd1);
    do_reset();
    idle(1);
    chk("tmo_cleared", 32'(err_o), 32'd0);

    // Reset in the middle of a wait.
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("rst_mid_wait_req", 32'(req_o), 32'd0);

    // Perf scenario: 3 freeze cycles, 1 bubble, 2 flushes.
    do_reset();
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 1, 4, 4, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(1);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall", stall_o,  32'd4);
    chk("perf_flush", flushc_o, 32'd2);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 800; i++) begin
      bit mop;
      mop = ($urandom_range(0, 2) == 0);
      step(($urandom_range(0, 99) == 0),
           bit'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)),
           bit'($urandom_range(0, 1)),
           mop && bit'($urandom_range(0, 1)),
           mop && bit'($urandom_range(0, 1)) || (mop && 1'b0),
           ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard controller for the 5-stage MIPS core; sits in ID stage and sequences stalls, bubbles and flushes.
- Detects load-use hazards and drives the bubble select (`IsHazzard_o`) into the ID/EX control-zeroing mux.
- Flushes IF/ID on a taken branch.
- Runs a handshake FSM that freezes the whole pipeline while a variable-latency data-memory access in MEM completes, with a watchdog timeout.

## Interface
Parameters:
- `REG_W`, 5, register-index width
- `TIMEOUT`, 64, max cycles in MEM_WAIT before abort (≥2)

Ports:
- `clk_i`  in  1  single clock; all state updates on rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `IDEX_MemRead_i`  in  1  instruction in EX is a load
- `IDEX_RegisterRt_i`  in  REG_W  load destination in EX
- `IFID_RegisterRs_i`, `IFID_RegisterRt_i`  in  REG_W  sources of instruction in ID
- `Branch_taken_i`  in  1  branch in ID resolved taken
- `EXMEM_MemRead_i`, `EXMEM_MemWrite_i`  in  1  memory op in MEM stage
- `DMem_ack_i`  in  1  data memory completes current access
- `DMem_req_o`  out  1  data memory request (level)
- `IsHazzard_o`  out  1  insert bubble into ID/EX
- `PC_write_o`  out  1  PC update enable
- `IFID_write_o`  out  1  IF/ID register enable
- `IFID_flush_o`  out  1  clear IF/ID to NOP
- `Freeze_o`  out  1  hold ID/EX, EX/MEM, MEM/WB
- `Timeout_err_o`  out  1  sticky watchdog error
- `Stall_cnt_o`, `Flush_cnt_o`  out  32  perf counters (only with macro)

## Operation
- FSM states: RUN, MEM_WAIT.
- `memop` = `EXMEM_MemRead_i | EXMEM_MemWrite_i`.
- `DMem_req_o` = (RUN & `memop`) | MEM_WAIT.
- `Freeze_o` = `DMem_req_o & ~DMem_ack_i`.
- Transitions:
  - RUN→MEM_WAIT: `memop & ~DMem_ack_i`.
  - RUN stays RUN if ack arrives in the same cycle (zero-wait access).
  - MEM_WAIT→RUN: `DMem_ack_i`, or watchdog reaching TIMEOUT.
- Watchdog: cleared on entering MEM_WAIT; increments each MEM_WAIT cycle without ack.
  - When count = TIMEOUT-1 without ack: set `Timeout_err_o` (sticky until reset).
  - Same cycle: force `Freeze_o`=0 and return to RUN; the instruction advances, no re-request.
- Load-use: `lu` = `IDEX_MemRead_i` & `IDEX_RegisterRt_i`≠0 & (Rt==`IFID_RegisterRs_i` | Rt==`IFID_RegisterRt_i`).
- Output priority:
  1. Freeze (highest): `PC_write_o`=0, `IFID_write_o`=0, `IsHazzard_o`=0, `IFID_flush_o`=0.
  2. Load-use (no freeze, `lu`=1): `IsHazzard_o`=1, `PC_write_o`=0, `IFID_write_o`=0, flush suppressed. A coincident branch is re-evaluated next cycle.
  3. Branch (no freeze, no `lu`): `IFID_flush_o`=`Branch_taken_i`; `PC_write_o`=1, `IFID_write_o`=1.
  4. Otherwise: `PC_write_o`=1, `IFID_write_o`=1, others 0.

## Timing
- Hazard outputs are combinational from inputs and state (Mealy); no added latency.
- A load-use bubble lasts exactly 1 cycle, since the bubble clears `IDEX_MemRead_i`.
- Memory access with ack k cycles after first request: `Freeze_o` high for k cycles; pipeline advances on the ack cycle's edge.
- Reset (any state, including mid-MEM_WAIT): state=RUN, watchdog=0, `Timeout_err_o`=0, counters=0.
- Reset outputs with inputs idle: `DMem_req_o`=0, `Freeze_o`=0, `IsHazzard_o`=0, `IFID_flush_o`=0, `PC_write_o`=1, `IFID_write_o`=1.
- Ack while in RUN with `memop`=0 is ignored.

## Configuration
- Macro: `HAZARD_PERF_CNT_EN`.
- Defined:
  - `Stall_cnt_o` increments each cycle with `Freeze_o` | `IsHazzard_o`.
  - `Flush_cnt_o` increments each cycle with `IFID_flush_o`.
  - Both 32-bit, saturating at 0xFFFFFFFF, zeroed by reset.
- Undefined: both ports and counters are absent.

## Test plan
- Load-use: `IDEX_MemRead_i`=1, Rt=5, `IFID_RegisterRs_i`=5 → one cycle `IsHazzard_o`=1, `PC_write_o`=0, `IFID_write_o`=0; Rt=0 with Rs=0 → no bubble.
- Taken branch, no hazard → `IFID_flush_o`=1 one cycle. Taken branch coincident with load-use → flush=0, bubble=1; flush asserted next cycle.
- Memory wait: `EXMEM_MemRead_i`=1, ack 3 cycles later → `DMem_req_o` high 4 cycles, `Freeze_o` high 3 cycles, state returns RUN. Zero-wait ack → `Freeze_o` never high.
- Timeout: TIMEOUT=8, no ack → `Freeze_o` drops after 8 cycles, `Timeout_err_o`=1 and stays 1 until `rst_i`.
- Reset mid-MEM_WAIT: assert `rst_i` on cycle 2 of wait → next cycle `DMem_req_o`=0 (if `memop`=0), `Freeze_o`=0, `Timeout_err_o`=0.
- With `HAZARD_PERF_CNT_EN`: 3 freeze cycles + 1 bubble + 2 flushes → `Stall_cnt_o`=4, `Flush_cnt_o`=2.
